fb_serial_rx: RTL and testbench
===============================

// Module: fb_serial_rx
// PURPOSE
// - Chip-side front end of the serial feedback-in port (fb_en/fb_d_in_vld/fb_d_in/fb_d_clsc) on top.
// - Deserialises the 1-bit stream MSB-first into WORD_W-bit words and tags the frame's last word.
// - Buffers words in a small FIFO for the downstream consumer, a CSR/bus-side frame handler, over valid/ready.
// - Reports framing errors and overflow through sticky flags.
// PARAMETERS
// - WORD_W  32  deserialised word width; must be >= 2.
// - DEPTH   8   output FIFO entries; must be a power of 2 and >= 2.
// PORTS
// - clk           in   1                  core clock
// - rst           in   1                  synchronous, active-high reset
// - fb_en         in   1                  port enable; low aborts the current frame
// - fb_d_in_vld   in   1                  fb_d_in/fb_d_clsc qualify this cycle
// - fb_d_in       in   1                  serial data bit, MSB first
// - fb_d_clsc     in   1                  qualified with the bit: this bit closes the frame
// - out_vld       out  1                  FIFO head valid
// - out_rdy       in   1                  consumer accepts the head when out_vld & out_rdy
// - out_data      out  WORD_W             FIFO head word
// - out_last      out  1                  head word is the last word of its frame
// - frame_err     out  1                  sticky: clsc off a word boundary (or parity fail)
// - ovf           out  1                  sticky: a word completed while the FIFO was full
// - err_clr       in   1                  one-cycle pulse; clears frame_err and ovf
// - level         out  $clog2(DEPTH)+1    FIFO occupancy
// BEHAVIOUR
// - Reset: FSM=IDLE, bit_cnt=0, shift reg=0, FIFO empty; out_vld=0, out_data=0, out_last=0, frame_err=0, ovf=0, level=0.
// - A bit is taken when fb_en & fb_d_in_vld. shreg <= {shreg[WORD_W-2:0], fb_d_in}; bit_cnt increments.
// - IDLE: the first taken bit moves the FSM to SHIFT and that bit is shifted in.
// - SHIFT: when bit_cnt reaches WORD_W-1 on a taken bit, the word is complete.
//   - Completed word is pushed in the same cycle; it is visible on out_vld the next cycle (1-cycle latency).
//   - out_last = fb_d_clsc of that final bit.
//   - bit_cnt wraps to 0. FSM goes to IDLE if clsc, otherwise stays in SHIFT.
// - clsc on a bit other than bit WORD_W-1: set frame_err, discard the partial word, push nothing, go to IDLE.
// - Complete word while the FIFO is full and not popping in that cycle:
//   - set ovf, drop the word, go to DISCARD (or IDLE if that bit carried clsc).
// - DISCARD: taken bits are ignored until a bit carrying clsc arrives, then go to IDLE. Already-buffered words are unaffected.
// - Push and pop in the same cycle with the FIFO full: allowed. The pop frees the slot and the push succeeds; no ovf.
// - Push and pop in the same cycle with the FIFO empty: the word is not bypassed. It appears the next cycle.
// - fb_en low in any state: FSM->IDLE and bit_cnt->0 on the next edge; the partial word is discarded with no error. FIFO contents are kept.
// - err_clr coinciding with a new error event: the set wins.
// - The FIFO pop is independent of fb_en. The consumer may drain the FIFO while the port is disabled.
// - fb_d_in_vld with fb_en low is ignored.
// CONFIGURATION
// - Macro FB_SERIAL_RX_PARITY_EN: selects whether each word carries a trailing parity bit.
// - Defined:
//   - Each word is WORD_W+1 bits; the extra bit is even parity over the word.
//   - clsc is valid only on the parity bit.
//   - A parity mismatch sets frame_err and drops the word (not pushed), then follows the frame's clsc/continue rules.
//   - bit_cnt counts to WORD_W.
// - Undefined: no parity bit; behaviour as above.
// STRUCTURE
// - fb_pkg (shared): fb_rx_state_e {FB_IDLE, FB_SHIFT, FB_DISCARD}; fb_word_t (struct {logic last; logic [WORD_W-1:0] data}); localparam FB_WORD_W_DEF=32.
// - Sub-module fb_rx_fifo: synchronous FIFO of fb_word_t, registered output, push/pop/full/empty/level.
// - Top of this file: FSM, bit counter, shift register, error flags.
// TESTING
// - 1 frame, 2 words: 0xDEADBEEF, then 0x12345678 with clsc on bit 63, out_rdy=1.
//   -> out_data DEADBEEF (last=0), then 12345678 (last=1); frame_err=0.
// - clsc on bit 10 of a frame -> frame_err=1, nothing pushed, level stays 0; the next valid frame is received normally.
// - out_rdy=0, DEPTH=8; send 9 words in one frame, clsc on word 9.
//   -> level=8, ovf=1; words 0-7 are intact; word 9 is also discarded.
// - fb_en dropped after 17 bits, then re-asserted with a fresh 32-bit word 0x00000001.
//   -> only 0x00000001 is pushed; frame_err=0.
// - FIFO full with out_rdy=1 in the cycle a word completes -> no ovf; level stays 8.
// - PARITY_EN: word 0x00000003 sent with parity bit 1 (bad) -> frame_err=1, nothing pushed.
//   Same word with parity bit 0 -> pushed.
// - err_clr pulse -> flags read 0 the next cycle. rst mid-word -> all outputs return to reset values.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types for the serial feedback-in receive path.
package fb_pkg;

    // Default deserialised word width.
    localparam int unsigned FB_WORD_W_DEF = 32;

    // Receive sequencer states.
    typedef enum logic [1:0] {
        FB_IDLE    = 2'd0,
        FB_SHIFT   = 2'd1,
        FB_DISCARD = 2'd2
    } fb_rx_state_e;

    // One buffered word at the default width: frame-last tag plus data.
    typedef struct packed {
        logic                     last;
        logic [FB_WORD_W_DEF-1:0] data;
    } fb_word_t;

endpackage : fb_pkg

// File: rtl/fb_rx_fifo.sv
// Synchronous FIFO of {last, data} words for the feedback-in receive path.
// The head entry is read straight from the storage registers. A word pushed
// into an empty FIFO therefore shows up one cycle later, with no bypass.
// Push and pop in the same cycle on a full FIFO are both accepted.
module fb_rx_fifo
    import fb_pkg::*;
#(
    parameter int unsigned WORD_W = FB_WORD_W_DEF,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WORD_W-1:0]        i_data,
    input  logic                     i_last,
    input  logic                     i_pop,
    output logic                     o_vld,
    output logic                     o_full,
    output logic [WORD_W-1:0]        o_data,
    output logic                     o_last,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    // Storage entry: frame-last tag plus data word.
    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } word_t;

    word_t              r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LVL_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_push  = i_push && (!w_full || w_pop);

    // Storage write, pointer advance and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{last: i_last, data: i_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_vld   = !w_empty;
    assign o_full  = w_full;
    assign o_data  = r_mem[r_rd_ptr].data;
    assign o_last  = r_mem[r_rd_ptr].last;
    assign o_level = r_count;

endmodule : fb_rx_fifo

// File: rtl/fb_serial_rx.sv
// Chip-side receiver for the serial feedback-in port.
// It deserialises the bit stream MSB-first into words and tags the last
// word of each frame. Words are buffered in fb_rx_fifo for a valid/ready
// consumer. Framing errors and overflow are reported through sticky flags.
// Optional build macro FB_SERIAL_RX_PARITY_EN: each word is followed by an
// even-parity bit. In that build, clsc is valid only on the parity bit.
module fb_serial_rx
    import fb_pkg::*;
#(
    parameter int unsigned WORD_W = FB_WORD_W_DEF,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fb_en,
    input  logic                     fb_d_in_vld,
    input  logic                     fb_d_in,
    input  logic                     fb_d_clsc,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [WORD_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     frame_err,
    output logic                     ovf,
    input  logic                     err_clr,
    output logic [$clog2(DEPTH):0]   level
);

`ifdef FB_SERIAL_RX_PARITY_EN
    // The parity bit is serial position WORD_W; all WORD_W data bits are held.
    localparam int unsigned LAST_IDX = WORD_W;
    localparam int unsigned SHR_W    = WORD_W;
`else
    // The final data bit completes the word straight from the input pin,
    // so only WORD_W-1 bits need to be held.
    localparam int unsigned LAST_IDX = WORD_W - 1;
    localparam int unsigned SHR_W    = WORD_W - 1;
`endif
    localparam int unsigned CNT_W = $clog2(LAST_IDX + 1);

    fb_rx_state_e       r_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [SHR_W-1:0]   r_shreg;
    logic               r_frame_err;
    logic               r_ovf;

    logic               w_take;
    logic               w_collect;
    logic               w_at_last;
    logic               w_last_bit;
    logic               w_clsc_early;
    logic               w_par_ok;
    logic [WORD_W-1:0]  w_word;
    logic [SHR_W-1:0]   w_shreg_nxt;
    logic               w_fifo_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop_full;
    logic               w_set_ferr;

    // A bit is taken only while the port is enabled.
    assign w_take    = fb_en && fb_d_in_vld;
    assign w_collect = w_take && (r_state != FB_DISCARD);
    assign w_at_last = (r_bit_cnt == CNT_W'(LAST_IDX));

`ifdef FB_SERIAL_RX_PARITY_EN
    // The word is already complete in the shift register when the parity bit arrives.
    assign w_word      = r_shreg;
    assign w_par_ok    = ((^r_shreg) == fb_d_in);
    assign w_shreg_nxt = {r_shreg[SHR_W-2:0], fb_d_in};
`else
    assign w_word      = {r_shreg, fb_d_in};
    assign w_par_ok    = 1'b1;
    assign w_shreg_nxt = w_word[SHR_W-1:0];
`endif

    // Word-completion and error event decode for the current cycle.
    assign w_last_bit   = w_collect && w_at_last;
    assign w_clsc_early = w_collect && fb_d_clsc && !w_at_last;
    assign w_pop        = out_vld && out_rdy;
    assign w_push       = w_last_bit && w_par_ok;
    assign w_drop_full  = w_push && w_fifo_full && !w_pop;
    assign w_set_ferr   = w_clsc_early || (w_last_bit && !w_par_ok);

    // Receive sequencer: state, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FB_IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (!fb_en) begin
            // Disabling the port silently abandons any partial word.
            r_state   <= FB_IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
        end else if (w_take) begin
            case (r_state)
                FB_DISCARD: begin
                    if (fb_d_clsc) begin
                        r_state <= FB_IDLE;
                    end
                end
                default: begin
                    if (w_at_last) begin
                        r_bit_cnt <= '0;
                        r_shreg   <= w_shreg_nxt;
                        if (fb_d_clsc) begin
                            r_state <= FB_IDLE;
                        end else if (w_drop_full) begin
                            r_state <= FB_DISCARD;
                        end else begin
                            r_state <= FB_SHIFT;
                        end
                    end else if (fb_d_clsc) begin
                        r_state   <= FB_IDLE;
                        r_bit_cnt <= '0;
                        r_shreg   <= '0;
                    end else begin
                        r_state   <= FB_SHIFT;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_shreg   <= w_shreg_nxt;
                    end
                end
            endcase
        end
    end

    // Sticky error flags; a new error event takes priority over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_set_ferr) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_drop_full) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign frame_err = r_frame_err;
    assign ovf       = r_ovf;

    fb_rx_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_last  (fb_d_clsc),
        .i_pop   (out_rdy),
        .o_vld   (out_vld),
        .o_full  (w_fifo_full),
        .o_data  (out_data),
        .o_last  (out_last),
        .o_level (level)
    );

endmodule : fb_serial_rx

// File: tb/tb_fb_serial_rx.sv
// Directed bench for fb_serial_rx, WORD_W=32 and DEPTH=8.
// Inputs are driven on the falling edge and outputs are sampled there too.
module tb_fb_serial_rx;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 8;
`ifdef FB_SERIAL_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              fb_en;
    logic              fb_d_in_vld;
    logic              fb_d_in;
    logic              fb_d_clsc;
    logic              out_vld;
    logic              out_rdy;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              frame_err;
    logic              ovf;
    logic              err_clr;
    logic [3:0]        level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WORD_W-1:0] exp5 [8];

    fb_serial_rx #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .fb_en       (fb_en),
        .fb_d_in_vld (fb_d_in_vld),
        .fb_d_in     (fb_d_in),
        .fb_d_clsc   (fb_d_clsc),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .out_last    (out_last),
        .frame_err   (frame_err),
        .ovf         (ovf),
        .err_clr     (err_clr),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic d, input logic c, input logic ec);
        @(negedge clk);
        fb_en       = 1'b1;
        fb_d_in_vld = 1'b1;
        fb_d_in     = d;
        fb_d_clsc   = c;
        err_clr     = ec;
    endtask

    task automatic idle();
        @(negedge clk);
        fb_d_in_vld = 1'b0;
        fb_d_in     = 1'b0;
        fb_d_clsc   = 1'b0;
        err_clr     = 1'b0;
    endtask

    // Sends one word MSB first (plus parity bit when enabled). c marks the
    // frame close. rl raises out_rdy together with the word's final bit.
    task automatic send_word(input logic [WORD_W-1:0] w, input logic c, input logic rl);
        for (int i = WORD_W - 1; i >= 0; i--) begin
            send_bit(w[i], (i == 0) && c && !PAR, 1'b0);
        end
        if (PAR) send_bit(^w, c, 1'b0);
        if (rl) out_rdy = 1'b1;
    endtask

    initial begin
        rst = 1'b1; fb_en = 1'b0; fb_d_in_vld = 1'b0; fb_d_in = 1'b0;
        fb_d_clsc = 1'b0; out_rdy = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vld",  64'(out_vld),   64'd0);
        chk("rst_data", 64'(out_data),  64'd0);
        chk("rst_last", 64'(out_last),  64'd0);
        chk("rst_ferr", 64'(frame_err), 64'd0);
        chk("rst_ovf",  64'(ovf),       64'd0);
        chk("rst_lvl",  64'(level),     64'd0);
        rst = 1'b0;

        // Two-word frame, consumer always ready.
        out_rdy = 1'b1;
        send_word(32'hDEADBEEF, 1'b0, 1'b0);
        idle();
        chk("f1_w0_vld",  64'(out_vld),  64'd1);
        chk("f1_w0_data", 64'(out_data), 64'hDEADBEEF);
        chk("f1_w0_last", 64'(out_last), 64'd0);
        send_word(32'h12345678, 1'b1, 1'b0);
        idle();
        chk("f1_w1_vld",  64'(out_vld),   64'd1);
        chk("f1_w1_data", 64'(out_data),  64'h12345678);
        chk("f1_w1_last", 64'(out_last),  64'd1);
        chk("f1_ferr",    64'(frame_err), 64'd0);
        idle();
        chk("f1_drained", 64'(level), 64'd0);

        // clsc on bit 10 is a framing error; nothing is pushed.
        out_rdy = 1'b0;
        for (int i = 0; i < 10; i++) send_bit(1'(i), 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        idle();
        chk("early_ferr", 64'(frame_err), 64'd1);
        chk("early_lvl",  64'(level),     64'd0);
        chk("early_vld",  64'(out_vld),   64'd0);
        err_clr = 1'b1;
        idle();
        chk("clr_ferr", 64'(frame_err), 64'd0);
        send_word(32'hA5A50F0F, 1'b1, 1'b0);
        idle();
        chk("after_err_lvl",  64'(level),     64'd1);
        chk("after_err_data", 64'(out_data),  64'hA5A50F0F);
        chk("after_err_last", 64'(out_last),  64'd1);
        chk("after_err_ferr", 64'(frame_err), 64'd0);
        out_rdy = 1'b1;
        idle();
        out_rdy = 1'b0;
        chk("after_err_drain", 64'(level), 64'd0);

        // Nine words into an 8-deep FIFO with no consumer: ninth overflows.
        for (int k = 0; k < 9; k++) send_word(32'h10000000 + 32'(k), k == 8, 1'b0);
        idle();
        chk("ovf_lvl",  64'(level),     64'd8);
        chk("ovf_flag", 64'(ovf),       64'd1);
        chk("ovf_ferr", 64'(frame_err), 64'd0);
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("ovf_keep_vld",  64'(out_vld),  64'd1);
            chk("ovf_keep_data", 64'(out_data), 64'h10000000 + 64'(k));
            idle();
        end
        chk("ovf_drain_lvl", 64'(level), 64'd0);
        out_rdy = 1'b0;
        err_clr = 1'b1;
        idle();
        chk("ovf_clr", 64'(ovf), 64'd0);

        // fb_en dropped mid-word: partial word vanishes without error.
        for (int i = 0; i < 17; i++) send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        fb_en = 1'b0;
        fb_d_in_vld = 1'b1;
        fb_d_in = 1'b1;
        send_word(32'h00000001, 1'b1, 1'b0);
        idle();
        chk("en_lvl",  64'(level),     64'd1);
        chk("en_data", 64'(out_data),  64'h00000001);
        chk("en_ferr", 64'(frame_err), 64'd0);
        out_rdy = 1'b1;
        idle();
        out_rdy = 1'b0;

        // Full FIFO with a pop in the completion cycle: no overflow.
        for (int k = 0; k < 8; k++) send_word(32'h20000000 + 32'(k), 1'b0, 1'b0);
        idle();
        chk("full_lvl", 64'(level), 64'd8);
        chk("full_ovf", 64'(ovf),   64'd0);
        send_word(32'h20000008, 1'b1, 1'b1);
        idle();
        out_rdy = 1'b0;
        chk("pp_lvl",  64'(level),    64'd8);
        chk("pp_ovf",  64'(ovf),      64'd0);
        chk("pp_head", 64'(out_data), 64'h20000001);

        // Overflow without clsc enters discard until the frame closes.
        send_word(32'hBAD00001, 1'b0, 1'b0);
        idle();
        chk("disc_ovf", 64'(ovf),   64'd1);
        chk("disc_lvl", 64'(level), 64'd8);
        out_rdy = 1'b1;
        idle();
        out_rdy = 1'b0;
        chk("disc_pop_lvl",  64'(level),    64'd7);
        chk("disc_pop_head", 64'(out_data), 64'h20000002);
        send_word(32'hBAD00002, 1'b1, 1'b0);
        idle();
        chk("disc_ignored", 64'(level), 64'd7);
        send_word(32'hCAFEF00D, 1'b1, 1'b0);
        idle();
        chk("disc_resume", 64'(level), 64'd8);
        for (int k = 0; k < 7; k++) exp5[k] = 32'h20000002 + 32'(k);
        exp5[7] = 32'hCAFEF00D;
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("disc_drain_data", 64'(out_data), 64'(exp5[k]));
            chk("disc_drain_last", 64'(out_last), 64'(k >= 6));
            idle();
        end
        chk("disc_drain_lvl", 64'(level), 64'd0);
        out_rdy = 1'b0;

        // err_clr in the same cycle as a new framing error: the set wins.
        err_clr = 1'b1;
        idle();
        chk("pre_clr_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b1);
        idle();
        chk("set_wins", 64'(frame_err), 64'd1);

`ifdef FB_SERIAL_RX_PARITY_EN
        // Bad parity drops the word; good parity pushes it.
        err_clr = 1'b1;
        idle();
        for (int i = WORD_W - 1; i >= 0; i--) send_bit((i < 2), 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        idle();
        chk("par_bad_ferr", 64'(frame_err), 64'd1);
        chk("par_bad_lvl",  64'(level),     64'd0);
        send_word(32'h00000003, 1'b1, 1'b0);
        idle();
        chk("par_ok_lvl",  64'(level),    64'd1);
        chk("par_ok_data", 64'(out_data), 64'h00000003);
`endif

        // Reset in the middle of a word with buffered data and flags set.
        send_word(32'h11111111, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0, 1'b0);
        idle();
        chk("pre_rst_lvl", 64'(level) != 64'd0, 64'd1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("mid_rst_vld",  64'(out_vld),   64'd0);
        chk("mid_rst_data", 64'(out_data),  64'd0);
        chk("mid_rst_last", 64'(out_last),  64'd0);
        chk("mid_rst_ferr", 64'(frame_err), 64'd0);
        chk("mid_rst_ovf",  64'(ovf),       64'd0);
        chk("mid_rst_lvl",  64'(level),     64'd0);
        send_word(32'h0F0F1234, 1'b1, 1'b0);
        idle();
        chk("post_rst_data", 64'(out_data), 64'h0F0F1234);
        chk("post_rst_lvl",  64'(level),    64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fb_serial_rx
